// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single 8-bit SDRAM port between the ROM download
// (dio), video fetch (vid) and the Z80 CPU. One access is granted per SDRAM
// slot. The winner's address, data and direction are latched at the grant.
// Read data is captured a fixed number of cycles later, and a one-cycle ack
// is returned to the winner.
//
// Handshake: each req is a level that is sampled only on a slot pulse while
// the arbiter is IDLE. An access completes when the matching ack is high for
// exactly one cycle; read data (vid_data / cpu_dout) is valid in that cycle
// and holds until the same requester's next read. A requester that keeps req
// high into the next slot is asking for a new access. A req dropped before it
// is granted is simply withdrawn.
module sdram_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_LAT = 6,
  parameter int CPU_MAX  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slot,
  input  logic              dio_req,
  input  logic [ADDR_W-1:0] dio_addr,
  input  logic [7:0]        dio_data,
  output logic              dio_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [7:0]        cpu_dout,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_din,
  output logic              sd_we,
  output logic              sd_oe,
  input  logic [7:0]        sd_dout
);

  localparam int CNT_W = $clog2(DATA_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  typedef enum logic [1:0] {OWN_DIO, OWN_VID, OWN_CPU} owner_t;

  state_t            state;
  owner_t            owner;
  logic [CNT_W-1:0]  lat_cnt;
  logic [1:0]        cpu_wait;

  logic cpu_boost;
  logic pick_dio;
  logic pick_vid;
  logic pick_cpu;
  logic any_req;

  // Winner selection: dio > starved cpu > vid > cpu.
  always_comb begin
    cpu_boost = cpu_req && (int'(cpu_wait) >= CPU_MAX);
    pick_dio  = dio_req;
    pick_cpu  = !dio_req && cpu_req && (cpu_boost || !vid_req);
    pick_vid  = !dio_req && vid_req && !cpu_boost;
    any_req   = dio_req || vid_req || cpu_req;
  end

  // Arbitration FSM with registered SDRAM-side and requester-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= OWN_DIO;
      lat_cnt  <= '0;
      cpu_wait <= '0;
      sd_addr  <= '0;
      sd_din   <= '0;
      sd_we    <= 1'b0;
      sd_oe    <= 1'b0;
      dio_ack  <= 1'b0;
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      vid_data <= '0;
      cpu_dout <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (slot) begin
            // A waiting CPU ages only on slots that grant someone else.
            if (!cpu_req || pick_cpu) begin
              cpu_wait <= '0;
            end else if (cpu_wait != 2'b11) begin
              cpu_wait <= cpu_wait + 2'd1;
            end
            if (any_req) begin
              state   <= BUSY;
              lat_cnt <= '0;
              if (pick_dio) begin
                owner   <= OWN_DIO;
                sd_addr <= dio_addr;
                sd_din  <= dio_data;
                sd_we   <= 1'b1;
                sd_oe   <= 1'b0;
              end else if (pick_cpu) begin
                owner   <= OWN_CPU;
                sd_addr <= cpu_addr;
                sd_din  <= cpu_din;
                sd_we   <= cpu_we;
                sd_oe   <= !cpu_we;
              end else begin
                owner   <= OWN_VID;
                sd_addr <= vid_addr;
                sd_din  <= '0;
                sd_we   <= 1'b0;
                sd_oe   <= 1'b1;
              end
            end
          end
        end

        BUSY: begin
          // Slot pulses are deliberately ignored here; the window is owned.
          if (lat_cnt == CNT_W'(DATA_LAT)) begin
            state <= ACK;
            sd_we <= 1'b0;
            sd_oe <= 1'b0;
            case (owner)
              OWN_DIO: dio_ack <= 1'b1;
              OWN_VID: begin
                vid_ack  <= 1'b1;
                vid_data <= sd_dout;
              end
              OWN_CPU: begin
                cpu_ack <= 1'b1;
                if (sd_oe) begin
                  cpu_dout <= sd_dout;
                end
              end
              default: ;
            endcase
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end

        ACK: begin
          dio_ack <= 1'b0;
          vid_ack <= 1'b0;
          cpu_ack <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
